// File: rtl/plot_arbiter_if.sv
// Requester bus for plot_arbiter: packed per-requester pixel fields plus the
// one-hot ack that the arbiter returns combinationally.
interface plot_arbiter_if #(
  parameter int NREQ = 6
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [7*NREQ-1:0] req_y;
  logic [3*NREQ-1:0] req_colour;
  logic [NREQ-1:0]   ack;

  // pixel writers drive requests and watch ack
  modport master (output req, req_x, req_y, req_colour, input ack);
  // arbiter consumes requests and issues ack
  modport slave  (input req, req_x, req_y, req_colour, output ack);
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single vga_adapter plot port among NREQ pixel
// writers with a round-robin, one-pixel-per-clock grant. The granted pixel is
// registered onto x/y/colour/plot.
// Optional build macro PLOT_CLEAR_EN adds a full-screen clear sweep
// (CLEAR state, sweep counters, colour latch). Without it the block is a pure
// arbiter and the clear ports are inert (busy/done tied low).
module plot_arbiter #(
  parameter int NREQ  = 6,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  plot_arbiter_if.slave bus,
  input  logic          clear_start,
  input  logic [2:0]    clear_colour,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic [2:0]    colour,
  output logic          plot
);
  localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   rr_next;
  logic            gnt_any;
  logic            arb_en;
  logic [NREQ-1:0] gnt_oh;

  // sweep datapath seen by the output register (constant when clear is absent)
  logic            sweep_px;
  logic [7:0]      sx;
  logic [6:0]      sy;
  logic [2:0]      clr_col;

  // Rotating-priority search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && bus.req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  // One-hot grant; suppressed in reset, during clear and on the clear_start cycle.
  always_comb begin
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    bus.ack = arb_en ? gnt_oh : '0;
  end

  // Explicit wrap rather than relying on pointer overflow (NREQ need not be 2^n).
  assign rr_next = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);

`ifdef PLOT_CLEAR_EN
  localparam logic [7:0] SX_LAST = 8'(X_MAX);
  localparam logic [6:0] SY_LAST = 7'(Y_MAX);

  typedef enum logic {ARB, CLEAR} state_t;
  state_t state, state_nx;
  logic   sweep_end;  // last pixel already issued; one more CLEAR cycle to finish

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= ARB;
    else         state <= state_nx;
  end

  // Next-state: clear_start only counts in ARB; CLEAR exits one cycle after
  // the last pixel so clear_done and the first post-clear ack line up.
  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (clear_start) state_nx = CLEAR;
      CLEAR:   if (sweep_end)   state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  assign arb_en     = resetn && (state == ARB) && !clear_start;
  assign clear_busy = (state == CLEAR);
  assign sweep_px   = (state == CLEAR) && !sweep_end;

  // Sweep counters, colour latch and done pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sx         <= '0;
      sy         <= '0;
      clr_col    <= '0;
      sweep_end  <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (state == ARB && clear_start) begin
        sx        <= '0;
        sy        <= '0;
        clr_col   <= clear_colour;
        sweep_end <= 1'b0;
      end else if (state == CLEAR) begin
        if (sweep_end) begin
          clear_done <= 1'b1;
        end else if (sx == SX_LAST) begin
          sx <= '0;
          if (sy == SY_LAST) sweep_end <= 1'b1;
          else               sy <= sy + 7'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end
    end
  end
`else
  assign arb_en     = resetn;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
  assign sweep_px   = 1'b0;
  assign sx         = '0;
  assign sy         = '0;
  assign clr_col    = '0;
  wire unused_clear = &{1'b0, clear_start, clear_colour};
`endif

  // Plot port register: sweep pixel, else granted pixel, else idle (hold data).
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      rr_ptr <= '0;
    end else if (sweep_px) begin
      x      <= sx;
      y      <= sy;
      colour <= clr_col;
      plot   <= 1'b1;
    end else if (arb_en && gnt_any) begin
      x      <= bus.req_x[8*gnt_idx +: 8];
      y      <= bus.req_y[7*gnt_idx +: 7];
      colour <= bus.req_colour[3*gnt_idx +: 3];
      plot   <= 1'b1;
      rr_ptr <= rr_next;
    end else begin
      plot   <= 1'b0;
    end
  end
endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single `vga_adapter` plot port among all pixel writers: the four player heads, the timer bar, the winner marker and a built-in full-screen clear sweep. Requesters present a pixel with a req/ack handshake. A round-robin arbiter grants one pixel per clock. The granted pixel is registered onto `x`/`y`/`colour`/`plot`. This block replaces the fixed DRAW_P1..DRAW_WINNER sequencing in the top-level control FSM.

## Interface
Parameters:
- `NREQ`, 6, number of requesters; index 0 = P1 … 3 = P4, 4 = timer, 5 = winner
- `X_MAX`, 159, last column of the sweep
- `Y_MAX`, 119, last row of the sweep

Ports:
- `CLOCK_50`  in  1  system clock; the only clock
- `resetn`  in  1  synchronous, active-low reset
- `req`  in  NREQ  per-requester pixel request
- `req_x`  in  8*NREQ  packed column, requester i at bits [8i+7:8i]
- `req_y`  in  7*NREQ  packed row, requester i at bits [7i+6:7i]
- `req_colour`  in  3*NREQ  packed colour, requester i at bits [3i+2:3i]
- `ack`  out  NREQ  one-hot grant, combinational
- `clear_start`  in  1  one-cycle pulse that starts the screen clear
- `clear_colour`  in  3  fill colour; sampled when `clear_start` is accepted
- `clear_busy`  out  1  high while the sweep runs
- `clear_done`  out  1  one-cycle pulse after the last clear pixel
- `x`  out  8  to `vga_adapter.x`
- `y`  out  7  to `vga_adapter.y`
- `colour`  out  3  to `vga_adapter.colour`
- `plot`  out  1  to `vga_adapter.plot`

## Operation
- States: ARB, CLEAR.
- ARB:
  - The granted requester is the first i with `req[i]=1`, searching from `rr_ptr` upward and wrapping at NREQ-1 → 0.
  - `ack[i]=1` in the same cycle.
  - On the next edge: `x/y/colour` ← that requester's fields, `plot`←1, `rr_ptr` ← i+1 mod NREQ.
  - If no request is present: `plot`←0 and `x/y/colour` hold.
- Handshake:
  - A requester holds `req` and its fields stable until it sees `ack`.
  - At the edge where `ack` is high, the requester either drops `req` or presents its next pixel.
  - A requester that is granted and keeps requesting yields to any other pending requester (round-robin fairness). Worst-case wait is NREQ-1 cycles.
- ARB with `clear_start=1`:
  - No `ack` is issued that cycle, even if `req` is present.
  - Next state is CLEAR, `clear_busy`←1, the `clear_colour` value is latched, the sweep counters (sx, sy) ← (0, 0), and `plot`←0.
- CLEAR:
  - Each cycle: `x`←sx, `y`←sy, `colour`←latched colour, `plot`←1.
  - sx increments; at X_MAX, sx wraps to 0 and sy increments.
  - After the pixel (X_MAX, Y_MAX) is registered: state ← ARB, `clear_busy`←0, `clear_done`←1 for one cycle.
  - `ack` stays all-zero during CLEAR, so requests stall and are not lost.
  - `clear_start` is ignored during CLEAR.
- Width rules:
  - sx is 8 bits and sy is 7 bits; neither overflows because both compare-and-wrap before exceeding their maximum.
  - `rr_ptr` is $clog2(NREQ) bits with explicit wrap, not modulo by overflow.

## Timing
- Reset values, applied at the next edge with `resetn=0`:
  - `x`=0, `y`=0, `colour`=0, `plot`=0, `clear_busy`=0, `clear_done`=0
  - state=ARB, `rr_ptr`=0
  - `ack` is forced to 0 while `resetn=0`.
- Reset during CLEAR aborts the sweep: no `clear_done`, and requests are granted from the first cycle after reset.
- Grant-to-plot latency is 1 cycle: `ack` in cycle N gives `plot=1` with the data in cycle N+1.
- Peak throughput is one pixel per cycle, back-to-back across requesters.
- Clear timing, with `clear_start` in cycle N:
  - First clear pixel on the port in cycle N+2.
  - Last clear pixel in cycle N+1+(X_MAX+1)(Y_MAX+1), i.e. N+19201 at the defaults.
  - `clear_done` and the first post-clear `ack` are both in the following cycle, N+19202.

## Configuration
- `PLOT_CLEAR_EN` defined: the CLEAR state, sweep counters and colour latch are built as described above.
- `PLOT_CLEAR_EN` undefined:
  - The clear logic is removed and the state is permanently ARB.
  - `clear_start` and `clear_colour` are ignored.
  - `clear_busy` and `clear_done` are tied to 0.
  - All ports remain present so top-level wiring is unchanged.

## Test plan
- Single requester: `req`=6'b000001 with (x=10, y=20, colour=3'b001) → `ack[0]` the same cycle, next cycle `plot`=1 with x=10, y=20, colour=001; then `plot`=0 once `req` drops.
- All six requesting continuously from reset → `ack` order 0,1,2,3,4,5,0,… with one grant per cycle and `plot` continuously 1.
- `rr_ptr` fairness: req[3] and req[1] held after a grant to 2 → grants 3, then 1, then 3.
- `clear_start` in the same cycle as `req[0]`, with `clear_colour`=000 → no ack; 19200 consecutive plots covering (0,0)…(159,0),(0,1)…(159,119); `clear_done` pulses once; `req[0]` acked in the `clear_done` cycle.
- `resetn`=0 at sweep pixel 5000 → all outputs reach their reset values the next cycle, no `clear_done`, and a new `clear_start` restarts the sweep at (0,0).
- Build without `PLOT_CLEAR_EN`, pulse `clear_start` → `clear_busy`/`clear_done` stay 0 and arbitration continues uninterrupted.
